// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control unit.
//   - RV32 opcode constants for the decoded instruction classes
//   - ALU-op encodings carried down the pipe
//   - EX-operand forwarding select encodings
//   - packed control bundle produced by decode and held in ID/EX
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;  // address generation
    localparam logic [1:0] ALUOP_SUB    = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;  // R-type, funct fields decide
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;  // I-type ALU, funct3 decides

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,  // operand from register file
        FWD_WB  = 2'b01,  // operand from MEM/WB result
        FWD_MEM = 2'b10   // operand from EX/MEM result
    } fwd_sel_e;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational ID-stage decoder.
//   inst_valid_i  IF/ID holds a real instruction
//   op_i          7-bit opcode
//   ctrl_o        control bundle (all zero for bubble / unknown opcode)
//   valid_o       instruction is a recognised, valid instruction
//   use_rs1_o     instruction reads rs1
//   use_rs2_o     instruction reads rs2
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic         inst_valid_i,
    input  logic [6:0]   op_i,
    output ctrl_bundle_t ctrl_o,
    output logic         valid_o,
    output logic         use_rs1_o,
    output logic         use_rs2_o
);

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        valid_o   = 1'b0;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        if (inst_valid_i) begin
            case (op_i)
                OP_R: begin
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = ALUOP_RFUNCT;
                    valid_o         = 1'b1;
                    use_rs1_o       = 1'b1;
                    use_rs2_o       = 1'b1;
                end
                OP_I_ALU: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = ALUOP_IFUNCT;
                    valid_o         = 1'b1;
                    use_rs1_o       = 1'b1;
                end
                OP_LOAD: begin
                    ctrl_o.memread  = 1'b1;
                    ctrl_o.memtoreg = 1'b1;
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = ALUOP_ADD;
                    valid_o         = 1'b1;
                    use_rs1_o       = 1'b1;
                end
                OP_STORE: begin
                    ctrl_o.memwrite = 1'b1;
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.aluop    = ALUOP_ADD;
                    valid_o         = 1'b1;
                    use_rs1_o       = 1'b1;
                    use_rs2_o       = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl_o.branch   = 1'b1;
                    ctrl_o.aluop    = ALUOP_SUB;
                    valid_o         = 1'b1;
                    use_rs1_o       = 1'b1;
                    use_rs2_o       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control path of the 5-stage RV32 pipeline.
// Decodes the ID instruction, carries its control through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, applies branch flushes and produces the
// EX operand forwarding selects.
//   clk_i, rst_n_i            clock, async active-low reset
//   inst_valid_i, op_i        ID instruction valid / opcode
//   rs1_i, rs2_i, rd_i        ID register indices
//   branch_taken_i            EX branch resolved taken
//   stall_o, flush_o          hold PC+IF/ID / squash IF/ID
//   ex_*                      ID/EX control
//   fwd_a_o, fwd_b_o          EX operand forwarding selects
//   mem_*                     EX/MEM control
//   wb_*                      MEM/WB control and destination
module pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  inst_valid_i,
    input  logic [6:0]            op_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  branch_taken_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  ex_valid_o,
    output logic                  ex_branch_o,
    output logic                  ex_alusrc_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  mem_memread_o,
    output logic                  mem_memwrite_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o
);

    ctrl_bundle_t id_ctrl;
    logic         id_valid;
    logic         id_use_rs1;
    logic         id_use_rs2;

    ctrl_decode u_decode (
        .inst_valid_i (inst_valid_i),
        .op_i         (op_i),
        .ctrl_o       (id_ctrl),
        .valid_o      (id_valid),
        .use_rs1_o    (id_use_rs1),
        .use_rs2_o    (id_use_rs2)
    );

    // ID/EX
    logic                  id_ex_valid;
    ctrl_bundle_t          id_ex_ctrl;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic [REG_ADDR_W-1:0] id_ex_rs1;
    logic [REG_ADDR_W-1:0] id_ex_rs2;

    // EX/MEM
    logic                  ex_mem_memread;
    logic                  ex_mem_memwrite;
    logic                  ex_mem_regwrite;
    logic                  ex_mem_memtoreg;
    logic [REG_ADDR_W-1:0] ex_mem_rd;

    // MEM/WB
    logic                  mem_wb_regwrite;
    logic                  mem_wb_memtoreg;
    logic [REG_ADDR_W-1:0] mem_wb_rd;

    logic     load_use;
    logic     squash;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    // Forwarding select for one EX operand; the younger EX/MEM result wins.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (mem_wr && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = id_ex_valid && id_ex_ctrl.memread && (id_ex_rd != '0) &&
                   inst_valid_i &&
                   ((id_use_rs1 && (rs1_i == id_ex_rd)) ||
                    (id_use_rs2 && (rs2_i == id_ex_rd)));
        flush_o  = branch_taken_i;
        stall_o  = load_use && !branch_taken_i;
        squash   = stall_o || flush_o;
    end

    always_comb begin
        fwd_a = fwd_pick(id_ex_rs1, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
        fwd_b = fwd_pick(id_ex_rs2, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
    end

    // Source indices an instruction does not read, and rd of a non-instruction,
    // are stored as x0 so they can never match a forwarding or hazard compare.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            id_ex_valid <= 1'b0;
            id_ex_ctrl  <= CTRL_BUBBLE;
            id_ex_rd    <= '0;
            id_ex_rs1   <= '0;
            id_ex_rs2   <= '0;
        end else if (squash) begin
            id_ex_valid <= 1'b0;
            id_ex_ctrl  <= CTRL_BUBBLE;
            id_ex_rd    <= '0;
            id_ex_rs1   <= '0;
            id_ex_rs2   <= '0;
        end else begin
            id_ex_valid <= id_valid;
            id_ex_ctrl  <= id_ctrl;
            id_ex_rd    <= id_valid   ? rd_i  : '0;
            id_ex_rs1   <= id_use_rs1 ? rs1_i : '0;
            id_ex_rs2   <= id_use_rs2 ? rs2_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memtoreg <= 1'b0;
            ex_mem_rd       <= '0;
            mem_wb_regwrite <= 1'b0;
            mem_wb_memtoreg <= 1'b0;
            mem_wb_rd       <= '0;
        end else begin
            ex_mem_memread  <= id_ex_ctrl.memread;
            ex_mem_memwrite <= id_ex_ctrl.memwrite;
            ex_mem_regwrite <= id_ex_ctrl.regwrite;
            ex_mem_memtoreg <= id_ex_ctrl.memtoreg;
            ex_mem_rd       <= id_ex_rd;
            mem_wb_regwrite <= ex_mem_regwrite;
            mem_wb_memtoreg <= ex_mem_memtoreg;
            mem_wb_rd       <= ex_mem_rd;
        end
    end

    always_comb begin
        ex_valid_o     = id_ex_valid;
        ex_branch_o    = id_ex_ctrl.branch;
        ex_alusrc_o    = id_ex_ctrl.alusrc;
        ex_aluop_o     = ALUOP_W'(id_ex_ctrl.aluop);
        fwd_a_o        = fwd_a;
        fwd_b_o        = fwd_b;
        mem_memread_o  = ex_mem_memread;
        mem_memwrite_o = ex_mem_memwrite;
        wb_regwrite_o  = mem_wb_regwrite;
        wb_memtoreg_o  = mem_wb_memtoreg;
        wb_rd_o        = mem_wb_rd;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int RW = 5;
    localparam int AW = 2;

    localparam bit [6:0] R_T  = 7'b0110011;
    localparam bit [6:0] I_T  = 7'b0010011;
    localparam bit [6:0] LD_T = 7'b0000011;
    localparam bit [6:0] ST_T = 7'b0100011;
    localparam bit [6:0] BR_T = 7'b1100011;
    localparam bit [6:0] BAD  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          inst_valid_i = 1'b0;
    logic [6:0]    op_i = '0;
    logic [RW-1:0] rs1_i = '0, rs2_i = '0, rd_i = '0;
    logic          branch_taken_i = 1'b0;
    logic          stall_o, flush_o, ex_valid_o, ex_branch_o, ex_alusrc_o;
    logic [AW-1:0] ex_aluop_o;
    logic [1:0]    fwd_a_o, fwd_b_o;
    logic          mem_memread_o, mem_memwrite_o, wb_regwrite_o, wb_memtoreg_o;
    logic [RW-1:0] wb_rd_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_ADDR_W(RW), .ALUOP_W(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .inst_valid_i(inst_valid_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .branch_taken_i(branch_taken_i),
        .stall_o(stall_o), .flush_o(flush_o), .ex_valid_o(ex_valid_o),
        .ex_branch_o(ex_branch_o), .ex_alusrc_o(ex_alusrc_o), .ex_aluop_o(ex_aluop_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .mem_memread_o(mem_memread_o),
        .mem_memwrite_o(mem_memwrite_o), .wb_regwrite_o(wb_regwrite_o),
        .wb_memtoreg_o(wb_memtoreg_o), .wb_rd_o(wb_rd_o)
    );

    // One instruction's worth of control as it travels down the pipe.
    typedef struct packed {
        bit          valid, branch, memread, memwrite, memtoreg, alusrc, regwrite;
        bit [1:0]    aluop;
        bit [RW-1:0] rd, rs1, rs2;
    } instr_t;

    instr_t ex_m, mem_m, wb_m;
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     exp_stall;
    logic   obs_stall, obs_flush;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction-class table: what each opcode does and which sources it reads.
    function automatic instr_t decode_m(bit v, bit [6:0] op, bit [RW-1:0] s1, bit [RW-1:0] s2, bit [RW-1:0] d);
        instr_t t;
        bit u1, u2;
        t = '0; u1 = 0; u2 = 0;
        if (v) begin
            t.valid = 1;
            if (op == R_T)        begin t.regwrite = 1; t.aluop = 2; u1 = 1; u2 = 1; end
            else if (op == I_T)   begin t.alusrc = 1; t.regwrite = 1; t.aluop = 3; u1 = 1; end
            else if (op == LD_T)  begin t.memread = 1; t.memtoreg = 1; t.alusrc = 1; t.regwrite = 1; u1 = 1; end
            else if (op == ST_T)  begin t.memwrite = 1; t.alusrc = 1; u1 = 1; u2 = 1; end
            else if (op == BR_T)  begin t.branch = 1; t.aluop = 1; u1 = 1; u2 = 1; end
            else                  t.valid = 0;
        end
        if (t.valid) t.rd = d;
        t.rs1 = u1 ? s1 : '0;
        t.rs2 = u2 ? s2 : '0;
        return t;
    endfunction

    function automatic bit [1:0] fwd_m(bit [RW-1:0] r);
        if (mem_m.regwrite && mem_m.rd != 0 && mem_m.rd == r) return 2'b10;
        if (wb_m.regwrite && wb_m.rd != 0 && wb_m.rd == r)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_model();
        ex_m = '0; mem_m = '0; wb_m = '0;
    endtask

    // Called at a negedge: drive ID inputs, check every output, advance one clock.
    task automatic cycle(input bit v, input bit [6:0] op, input bit [RW-1:0] s1,
                         input bit [RW-1:0] s2, input bit [RW-1:0] d, input bit br);
        instr_t id;
        inst_valid_i = v; op_i = op; rs1_i = s1; rs2_i = s2; rd_i = d; branch_taken_i = br;
        #1;
        id = decode_m(v, op, s1, s2, d);
        exp_stall = ex_m.valid && ex_m.memread && ex_m.rd != 0 && id.valid && !br &&
                    (id.rs1 == ex_m.rd || id.rs2 == ex_m.rd);
        obs_stall = stall_o;
        obs_flush = flush_o;
        check_eq("stall", stall_o, exp_stall);
        check_eq("flush", flush_o, br);
        check_eq("ex_valid", ex_valid_o, ex_m.valid);
        check_eq("ex_branch", ex_branch_o, ex_m.branch);
        check_eq("ex_alusrc", ex_alusrc_o, ex_m.alusrc);
        check_eq("ex_aluop", ex_aluop_o, ex_m.aluop);
        check_eq("fwd_a", fwd_a_o, fwd_m(ex_m.rs1));
        check_eq("fwd_b", fwd_b_o, fwd_m(ex_m.rs2));
        check_eq("mem_memread", mem_memread_o, mem_m.memread);
        check_eq("mem_memwrite", mem_memwrite_o, mem_m.memwrite);
        check_eq("wb_regwrite", wb_regwrite_o, wb_m.regwrite);
        check_eq("wb_memtoreg", wb_memtoreg_o, wb_m.memtoreg);
        check_eq("wb_rd", wb_rd_o, wb_m.rd);
        @(posedge clk);
        if (rst_n_i) begin
            wb_m  = mem_m;
            mem_m = ex_m;
            ex_m  = (exp_stall || br) ? instr_t'('0) : id;
        end
        @(negedge clk);
    endtask

    // Present one instruction, holding it in IF/ID while the pipe stalls.
    task automatic issue(input bit [6:0] op, input bit [RW-1:0] s1, input bit [RW-1:0] s2,
                         input bit [RW-1:0] d);
        int tries;
        tries = 0;
        cycle(1, op, s1, s2, d, 0);
        while (exp_stall && tries < 4) begin
            cycle(1, op, s1, s2, d, 0);
            tries++;
        end
        if (exp_stall) check_eq("stall_bound", 1, 0);
    endtask

    task automatic nop();
        cycle(0, '0, '0, '0, '0, 0);
    endtask

    initial begin
        bit [6:0] ops [6];
        bit [6:0] op;
        bit [RW-1:0] s1, s2, d;
        bit v, br;
        ops[0] = R_T; ops[1] = I_T; ops[2] = LD_T; ops[3] = ST_T; ops[4] = BR_T; ops[5] = BAD;
        clear_model();

        // Reset held with random inputs.
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            cycle($urandom_range(0, 1), ops[$urandom_range(0, 5)], 5'($urandom), 5'($urandom),
                  5'($urandom), $urandom_range(0, 1));
        rst_n_i = 1'b1;
        // First instruction after reset.
        issue(R_T, 1, 2, 3);
        check_eq("rst_r_aluop", ex_aluop_o, 2'b10);
        nop(); nop();
        check_eq("rst_r_wb_regwrite", wb_regwrite_o, 1);
        check_eq("rst_r_wb_rd", wb_rd_o, 3);

        // Load-use: one stall, then forward from MEM/WB.
        issue(LD_T, 1, 0, 5);
        cycle(1, R_T, 5, 6, 8, 0);
        check_eq("lu_stall", obs_stall, 1);
        check_eq("lu_bubble", ex_valid_o, 0);
        cycle(1, R_T, 5, 6, 8, 0);
        check_eq("lu_stall_once", obs_stall, 0);
        check_eq("lu_fwd_a", fwd_a_o, 2'b01);
        nop(); nop(); nop();

        // EX/MEM beats MEM/WB; x0 never forwards or stalls.
        issue(I_T, 1, 0, 7);
        issue(I_T, 2, 0, 7);
        issue(R_T, 7, 7, 9);
        check_eq("prio_fwd_a", fwd_a_o, 2'b10);
        check_eq("prio_fwd_b", fwd_b_o, 2'b10);
        issue(I_T, 1, 0, 0);
        issue(I_T, 2, 0, 0);
        issue(R_T, 0, 0, 9);
        check_eq("x0_fwd_a", fwd_a_o, 2'b00);
        check_eq("x0_fwd_b", fwd_b_o, 2'b00);
        issue(LD_T, 1, 0, 0);
        cycle(1, R_T, 0, 0, 4, 0);
        check_eq("x0_no_stall", obs_stall, 0);
        nop(); nop(); nop();

        // Flush wins over a simultaneous load-use.
        issue(LD_T, 1, 0, 4);
        cycle(1, R_T, 4, 2, 6, 1);
        check_eq("fs_flush", obs_flush, 1);
        check_eq("fs_stall", obs_stall, 0);
        check_eq("fs_bubble", ex_valid_o, 0);
        nop(); nop(); nop();

        // Store, branch, illegal opcode.
        issue(ST_T, 2, 3, 6);
        nop();
        check_eq("st_memwrite", mem_memwrite_o, 1);
        nop();
        check_eq("st_regwrite", wb_regwrite_o, 0);
        issue(BR_T, 1, 2, 0);
        check_eq("br_branch", ex_branch_o, 1);
        check_eq("br_aluop", ex_aluop_o, 2'b01);
        issue(BAD, 1, 2, 9);
        check_eq("bad_valid", ex_valid_o, 0);
        check_eq("bad_aluop", ex_aluop_o, 0);
        check_eq("bad_alusrc", ex_alusrc_o, 0);
        nop(); nop();

        // Asynchronous reset with a load in EX/MEM.
        issue(LD_T, 1, 0, 5);
        nop();
        check_eq("ar_memread_before", mem_memread_o, 1);
        #2 rst_n_i = 1'b0;
        #1 check_eq("ar_memread_after", mem_memread_o, 0);
        clear_model();
        @(negedge clk);
        nop();
        rst_n_i = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) != 0);
            op = ops[$urandom_range(0, 5)];
            s1 = 5'($urandom_range(0, 7));
            s2 = 5'($urandom_range(0, 7));
            d  = 5'($urandom_range(0, 7));
            br = ($urandom_range(0, 9) == 0);
            cycle(v, op, s1, s2, d, br);
            if (exp_stall) cycle(v, op, s1, s2, d, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the 5-stage RV32 core. Decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Inserts bubbles on load-use hazards and taken-branch flushes, and generates EX-operand forwarding selects. Sits between the IF/ID register and the datapath stage registers, and owns every control-path flop after decode.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- ALUOP_W, 2, ALU-op field width (≥2; encodings zero-extended)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- inst_valid_i  in  1  IF/ID holds a real instruction
- op_i  in  7  ID opcode
- rs1_i, rs2_i, rd_i  in  REG_ADDR_W  ID register indices
- branch_taken_i  in  1  EX-stage branch resolved taken
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_o  out  1  squash IF/ID this cycle
- ex_valid_o, ex_branch_o, ex_alusrc_o  out  1  ID/EX control
- ex_aluop_o  out  ALUOP_W  ID/EX ALU op
- fwd_a_o, fwd_b_o  out  2  EX operand select
- mem_memread_o, mem_memwrite_o  out  1  EX/MEM control
- wb_regwrite_o, wb_memtoreg_o  out  1  MEM/WB control
- wb_rd_o  out  REG_ADDR_W  MEM/WB destination

## Operation
Decode (combinational, ID):
- 0110011 R: regwrite, aluop 10, uses rs1/rs2
- 0010011 I-ALU: alusrc, regwrite, aluop 11, uses rs1
- 0000011 load: memread, memtoreg, alusrc, regwrite, aluop 00, uses rs1
- 0100011 store: memwrite, alusrc, aluop 00, uses rs1/rs2
- 1100011 branch: branch, aluop 01, uses rs1/rs2
- Any other opcode, or inst_valid_i=0: all-zero bundle (bubble), no source use
- memtoreg is 0 for every non-load opcode, including store and branch

Hazards:
- Load-use: stall_o=1 when all of the following hold:
  - ex_valid_o and ID/EX memread are set
  - ID/EX rd is non-zero
  - ID/EX rd equals a source register the ID instruction uses
  - inst_valid_i is set
- flush_o = branch_taken_i.
- On stall or flush, ID/EX loads a bubble: all controls 0, valid 0, rd 0.
- EX/MEM and MEM/WB always advance.
- Flush takes priority over stall; stall_o is forced to 0 when branch_taken_i=1.

Forwarding (per operand, from registered ID/EX rs1/rs2):
- 10: EX/MEM regwrite, EX/MEM rd≠0, and EX/MEM rd matches the operand register
- else 01: MEM/WB regwrite, MEM/WB rd≠0, and MEM/WB rd matches
- else 00: register file
- EX/MEM wins when both stages match.

Register x0:
- Writes to rd=0 keep regwrite as decoded.
- rd=0 never triggers forwarding or a stall.

## Timing
- Instruction decoded in ID at cycle N:
  - ex_* outputs valid in N+1
  - mem_* outputs valid in N+2
  - wb_* outputs valid in N+3
- stall_o, flush_o and fwd_*_o are combinational from current inputs and registers, with no added latency.
- A stall lasts exactly one cycle per load-use pair. Next cycle the load is in MEM and the dependency resolves by forwarding (01 one cycle later).
- Reset (asynchronous assert, synchronous-safe deassert by the system): every pipeline flop clears to 0. All outputs are then 0, fwd_*=00, stall_o=0, flush_o=branch_taken_i.
- Reset mid-stream discards all in-flight control. The first post-reset ID instruction appears on ex_* one cycle after the first rising edge with rst_n_i=1.

## Structure
- Package ctrl_pkg holds:
  - opcode constants
  - ALUOP encodings (00 add, 01 sub/compare, 10 R-funct, 11 I-funct)
  - forward-select encodings (FWD_RF, FWD_MEM, FWD_WB)
  - a packed control-bundle struct: branch, memread, memwrite, memtoreg, alusrc, regwrite, aluop
- One sub-module, ctrl_decode: a pure combinational opcode→bundle plus use-rs1/use-rs2 decoder, instantiated once in ID.
- Stage registers, hazard logic and forwarding logic live in pipe_ctrl.

## Test plan
- Reset: hold rst_n_i=0 with random inputs → all outputs 0, fwd 00. Release, issue R-type op 0110011 with rd=3 → ex_aluop_o=10 at N+1, wb_regwrite_o=1 and wb_rd_o=3 at N+3.
- Load-use: load rd=5, then R-type with rs1=5 → stall_o=1 for one cycle, bubble in ID/EX (ex_valid_o=0). Then fwd_a_o=01 when the R-type reaches EX.
- Forwarding priority: addi rd=7; addi rd=7; R-type with rs1=rs2=7 → fwd_a_o=fwd_b_o=10. Same sequence with rd=0 → fwd 00 and no stall.
- Flush vs stall: branch_taken_i=1 in the same cycle as a load-use condition → flush_o=1, stall_o=0, ID/EX bubble next cycle.
- Store/branch/illegal: store → mem_memwrite_o=1 at N+2 and wb_regwrite_o=0. Branch → ex_branch_o=1 and aluop 01. Opcode 1111111 → all-zero bundle.
- Async reset mid-stream: drop rst_n_i between edges while a load is in EX/MEM → mem_memread_o falls immediately, without waiting for a clock edge.
